// File: rtl/bcd_counter_seg7_mux.sv
// Multi-digit BCD up/down counter with ripple carry/borrow, driving a scanned
// 7-segment display with optional leading-zero blanking and segment polarity.
`timescale 1ns/1ps
module bcd_counter_seg7_mux #(
    parameter int NUM_DIGITS     = 4,
    parameter int SCAN_DIV       = 16,
    parameter int LZ_BLANK       = 1,
    parameter int SEG_ACTIVE_LOW = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    inc,
    input  logic                    dec,
    input  logic                    clr,
    output logic [4*NUM_DIGITS-1:0] count_bcd,
    output logic                    ovf,
    output logic                    unf,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [6:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;

    logic [4*NUM_DIGITS-1:0] count_reg, count_next;
    logic                    ovf_reg, ovf_next;
    logic                    unf_reg, unf_next;
    logic [DIV_W-1:0]        presc_reg, presc_next;
    logic [IDX_W-1:0]        scan_idx_reg, scan_idx_next;
    logic [NUM_DIGITS-1:0]   an_reg, an_next;
    logic [6:0]              seg_reg, seg_next;

    logic [3:0]              digit [NUM_DIGITS];
    logic [4*NUM_DIGITS-1:0] count_inc, count_dec;
    logic                    all_nine, all_zero;
    logic [NUM_DIGITS-1:0]   blank;
    logic [6:0]              seg_raw;

    function automatic logic [6:0] seg_encode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1111110;
            4'd1:    s = 7'b0110000;
            4'd2:    s = 7'b1101101;
            4'd3:    s = 7'b1111001;
            4'd4:    s = 7'b0110011;
            4'd5:    s = 7'b1011011;
            4'd6:    s = 7'b1011111;
            4'd7:    s = 7'b1110000;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1111011;
            default: s = 7'b0000000;
        endcase
        return s;
    endfunction

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign digit[gi] = count_reg[4*gi +: 4];
        end
    endgenerate

    // Ripple chains: a digit steps only when every lower digit wrapped.
    always_comb begin
        logic c;
        logic b;
        logic z;
        count_inc = count_reg;
        count_dec = count_reg;
        blank     = '0;
        c = 1'b1;
        b = 1'b1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (c) count_inc[4*k +: 4] = (digit[k] == 4'd9) ? 4'd0 : digit[k] + 4'd1;
            if (b) count_dec[4*k +: 4] = (digit[k] == 4'd0) ? 4'd9 : digit[k] - 4'd1;
            c = c & (digit[k] == 4'd9);
            b = b & (digit[k] == 4'd0);
        end
        all_nine = c;
        all_zero = b;
        z = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            z = z & (digit[k] == 4'd0);
            blank[k] = (LZ_BLANK != 0) && (k != 0) && z;
        end
    end

    always_comb begin
        count_next = count_reg;
        ovf_next   = 1'b0;
        unf_next   = 1'b0;
        if (clr) begin
            count_next = '0;
        end else if (inc && !dec) begin
            count_next = count_inc;
            ovf_next   = all_nine;
        end else if (dec && !inc) begin
            count_next = count_dec;
            unf_next   = all_zero;
        end
    end

    always_comb begin
        presc_next    = presc_reg + DIV_W'(1);
        scan_idx_next = scan_idx_reg;
        if (presc_reg == DIV_W'(SCAN_DIV - 1)) begin
            presc_next    = '0;
            scan_idx_next = (scan_idx_reg == IDX_W'(NUM_DIGITS - 1)) ? '0
                                                                     : scan_idx_reg + IDX_W'(1);
        end
        an_next  = NUM_DIGITS'(1) << scan_idx_reg;
        seg_raw  = blank[scan_idx_reg] ? 7'h00 : seg_encode(digit[scan_idx_reg]);
        seg_next = seg_raw ^ SEG_OFF;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg    <= '0;
            ovf_reg      <= 1'b0;
            unf_reg      <= 1'b0;
            presc_reg    <= '0;
            scan_idx_reg <= '0;
            an_reg       <= '0;
            seg_reg      <= SEG_OFF;
        end else begin
            count_reg    <= count_next;
            ovf_reg      <= ovf_next;
            unf_reg      <= unf_next;
            presc_reg    <= presc_next;
            scan_idx_reg <= scan_idx_next;
            an_reg       <= an_next;
            seg_reg      <= seg_next;
        end
    end

    assign count_bcd = count_reg;
    assign ovf       = ovf_reg;
    assign unf       = unf_reg;
    assign an        = an_reg;
    assign seg       = seg_reg;

endmodule

// File: doc/bcd_counter_seg7_mux.md
Name: bcd_counter_seg7_mux

Overview:
- Parametrised multi-digit BCD up/down counter with a time-multiplexed 7-segment display driver.
- Next generation of the team's single-digit combinational BCD-to-7-segment decoder: adds N digits, registered counting with carry/borrow, digit scanning and leading-zero blanking.
- Sits between the board push-button/tick logic and the segment/anode pins.

Parameters:
NUM_DIGITS, 4, number of BCD digits (1..8); digit 0 is least significant.
SCAN_DIV, 16, clocks each digit is held active during scanning (>=1).
LZ_BLANK, 1, 1 = blank leading zero digits; 0 = show all digits.
SEG_ACTIVE_LOW, 0, 1 = invert seg outputs (common-anode board); an is unaffected.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
inc  input  1  increment request, sampled each clock.
dec  input  1  decrement request, sampled each clock.
clr  input  1  synchronous clear of the count to zero.
count_bcd  output  4*NUM_DIGITS  registered count; digit k is bits [4k+3:4k].
ovf  output  1  one-cycle pulse when an increment wraps from all-9s to 0.
unf  output  1  one-cycle pulse when a decrement wraps from 0 to all-9s.
an  output  NUM_DIGITS  one-hot active-high select of the digit being displayed.
seg  output  7  segments {a,b,c,d,e,f,g}; bit 6 = a.

Behaviour:
- Reset (rst_n low, async):
  - count_bcd = 0, ovf = unf = 0.
  - Prescaler = 0, scan index = 0.
  - an = 0; seg = all segments off (0, or 7'h7F when SEG_ACTIVE_LOW).
- Count update, priority order per clock edge:
  1. clr: count = 0. Overrides inc and dec; no ovf/unf.
  2. inc && dec both set: no change.
  3. inc only: BCD +1 with ripple carry. A digit at 9 becomes 0 and carries. All-9s becomes 0 and sets ovf for one cycle.
  4. dec only: BCD -1 with ripple borrow. A digit at 0 becomes 9 and borrows. All-0s becomes all-9s and sets unf for one cycle.
- Latency: count_bcd, ovf and unf are registered and change on the edge that samples the request (1-cycle latency).
- inc/dec are level-sensitive: held high, the count changes every clock. Edge detection is the caller's job.
- Digit values never exceed 9; no 10-15 state is reachable.
- Scan prescaler:
  - Counts 0..SCAN_DIV-1.
  - On terminal count it returns to 0 and the scan index advances.
  - The index wraps from NUM_DIGITS-1 to 0.
  - With SCAN_DIV = 1 the index advances every clock.
- Display outputs (registered):
  - Each clock: an = one-hot(scan index); seg = encode(digit[scan index]) from the current count register.
  - seg therefore lags a count change by at most 1 clock for the active digit.
  - First edge after reset release: an = 1 (digit 0), seg = pattern for digit 0.
- Encoding (active-high, a..g):
  0 = 1111110, 1 = 0110000, 2 = 1101101, 3 = 1111001, 4 = 0110011, 5 = 1011011, 6 = 1011111, 7 = 1110000, 8 = 1111111, 9 = 1111011.
- Leading-zero blanking (LZ_BLANK = 1):
  - Digit k > 0 shows all-off when it and all higher digits are 0.
  - Digit 0 is never blanked.
  - an still selects the blanked digit (uniform duty cycle).
- SEG_ACTIVE_LOW = 1: seg is the bitwise inverse of the active-high value, including the reset and blanked values.
- Reset asserted mid-scan or mid-count: all state clears immediately; no ovf/unf is emitted.

Test Plan:
- Bench configuration for all scenarios: NUM_DIGITS=4, SCAN_DIV=4, LZ_BLANK=1, SEG_ACTIVE_LOW=0.
- Reset, then release with inc=dec=clr=0 -> count_bcd=16'h0000; an sequence 0001 (4 clocks), 0010, 0100, 1000, 0001 repeating; seg=1111110 on digit 0, 0000000 on digits 1-3.
- Hold inc for 10 clocks from 0 -> count_bcd=16'h0010; digit 1 shows 0110000, digit 0 shows 1111110, digits 2-3 blank.
- Load 9999 via dec from 0 -> unf pulses exactly 1 cycle and count_bcd=16'h9999; then one inc -> count_bcd=16'h0000 and ovf pulses exactly 1 cycle.
- Starting at 16'h0100: one dec -> 16'h0099 (borrow across two digits, digit 2 now blanked); assert inc and dec together -> count holds 16'h0099; assert clr with inc -> 16'h0000, no ovf.
- Drive rst_n low for 1 ns mid-prescale with count 16'h0042 -> an=0, seg=0, count_bcd=0 asynchronously, without waiting for a clock edge; scanning restarts at digit 0.
- Rerun with SCAN_DIV=1, SEG_ACTIVE_LOW=1, count 16'h0008 -> an rotates every clock; seg=0000000 on digit 0, 1111111 on the blanked digits.
